vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA controller: all horizontal/vertical timing, sync polarity, pixel width and upstream pixel-fetch latency are parameters.
- Sits between the pixel source (pattern/picture generator, frame-buffer reader) and the VGA DAC pins.
- Issues a pixel request with coordinates REQ_LAT cycles ahead of the active region, so the source's registered data lands aligned with data-enable.
- Adds run/stop control, a frame-start pulse and a frame counter.

Parameters:
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- DATA_W, 16, pixel width (RGB565 default)
- CNT_W, 12, width of counters and coordinate outputs
- REQ_LAT, 1, upstream cycles from pix_req to valid pix_data, range 1..4

Ports:
- vga_clk  in  1  pixel clock
- sys_rst_n  in  1  async active-low reset
- en  in  1  run enable
- pix_data  in  DATA_W  pixel from source, valid REQ_LAT cycles after pix_req
- pix_req  out  1  pixel request
- pix_x  out  CNT_W  requested column, 0..H_ACTIVE-1 when pix_req is high, else 0
- pix_y  out  CNT_W  requested row, 0..V_ACTIVE-1 when pix_req is high, else 0
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- data_en  out  1  visible-region flag
- rgb  out  DATA_W  pixel out: pix_data when data_en is high, else 0
- frame_start  out  1  one-cycle pulse at the start of each frame
- frame_cnt  out  8  frame counter, wraps 255->0

Behaviour:
- Only one clock is used. Reset is asynchronous and active-low.
- Derived constants:
  - H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP
  - HA_S = H_SYNC+H_BP; HA_E = HA_S+H_ACTIVE
  - V_TOTAL, VA_S and VA_E are defined the same way.
- Register "run" is updated as run <= en each cycle. It resets to 0.
- Counters h_cnt and v_cnt:
  - Both reset to 0, and both are held at 0 while run=0.
  - While run=1, h_cnt increments and wraps at H_TOTAL-1 -> 0.
  - v_cnt increments when h_cnt wraps, and itself wraps at V_TOTAL-1 -> 0.
- All outputs are decoded combinationally from the registered counters and run. There is no extra pipeline stage.
- When run=1:
  - hsync = HS_POL while h_cnt < H_SYNC, else ~HS_POL.
  - vsync = VS_POL while v_cnt < V_SYNC, else ~VS_POL.
  - data_en = 1 when HA_S <= h_cnt < HA_E and VA_S <= v_cnt < VA_E.
  - pix_req = 1 when HA_S-REQ_LAT <= h_cnt < HA_E-REQ_LAT and v_cnt is in the active lines.
  - pix_x = h_cnt+REQ_LAT-HA_S; pix_y = v_cnt-VA_S.
  - rgb = data_en ? pix_data : 0.
  - frame_start = 1 when h_cnt==0 and v_cnt==0.
  - frame_cnt increments on the cycle frame_start is high.
- When run=0, or in reset:
  - hsync = ~HS_POL and vsync = ~VS_POL.
  - pix_req, data_en and frame_start are 0.
  - pix_x, pix_y and rgb are 0.
  - frame_cnt resets to 0 on reset and holds while run=0.
- en rise: the first run=1 cycle has h_cnt=0, v_cnt=0, so frame_start fires and a full frame begins with the sync pulse.
- en fall mid-frame: the next edge clears run, the partial frame is abandoned and outputs go inactive immediately. A restart always begins a fresh frame.
- Reset asserted mid-frame: all registers clear asynchronously and outputs take their inactive values at once.
- Each frame produces exactly H_ACTIVE*V_ACTIVE requests and the same number of data_en cycles. The pix_req pattern shifted by REQ_LAT cycles equals the data_en pattern.
- Elaboration must fail (generate-time error) if:
  - REQ_LAT > H_BP
  - H_TOTAL >= 2^CNT_W or V_TOTAL >= 2^CNT_W

Test Plan:
1. Defaults, en=1 from reset release:
   - hsync low for 96 cycles, period 800.
   - vsync low for 1600 cycles, period 420000.
   - Before release, hsync=vsync=1 and rgb=0.
2. Defaults, first visible pixel:
   - pix_req rises at v_cnt=35, h_cnt=143 with pix_x=0, pix_y=0.
   - data_en is high for h_cnt 144..783.
   - Source drives pix_data registered from pix_x; rgb on pixel N equals the value requested for N.
3. Defaults, frame accounting:
   - Last request is pix_x=639, pix_y=479 at h_cnt=782, v_cnt=514.
   - data_en count per frame is 307200.
   - frame_start pulses every 420000 cycles and frame_cnt steps 0->1->2.
4. en dropped at v_cnt=200, then raised 10 cycles later:
   - Outputs are inactive one edge after the drop, and frame_cnt holds.
   - On restart, frame_start fires on the first run cycle and hsync begins a full 96-cycle pulse.
5. Override HS_POL=1, VS_POL=1, REQ_LAT=3, H_ACTIVE=800, H_FP=40, H_BP=88, H_SYNC=128, V_* = 4/23/600/1:
   - hsync is high for 128 of 1056 cycles.
   - pix_req rises 3 cycles before data_en.
   - 480000 data_en cycles per frame.
6. sys_rst_n pulsed low mid-line:
   - All outputs go inactive asynchronously and frame_cnt returns to 0.
   - After release, timing restarts from h_cnt=0, v_cnt=0.

Source files
------------

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Parametrised VGA raster timing generator. Produces hsync/vsync,
//             a visible-region data-enable, and a pixel request with
//             coordinates issued REQ_LAT cycles ahead of data-enable, so a
//             source with REQ_LAT cycles of registered latency lands its
//             pixel exactly on the matching data-enable cycle. Also provides
//             run/stop control, a frame-start pulse and an 8-bit frame count.
//
//  Ports    : vga_clk_i      pixel clock
//             sys_rst_n_i    asynchronous active-low reset
//             en_i           run enable (sampled into run_q every cycle)
//             pix_data_i     pixel from source, valid REQ_LAT cycles after req
//             pix_req_o      pixel request
//             pix_x_o/_y_o   requested column/row (0 when no request)
//             hsync_o        horizontal sync, active level HS_POL
//             vsync_o        vertical sync, active level VS_POL
//             data_en_o      visible-region flag
//             rgb_o          pix_data_i while data_en_o, else 0
//             frame_start_o  one-cycle pulse on the first cycle of a frame
//             frame_cnt_o    frame counter, wraps 255 -> 0
//
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int DATA_W   = 16,
  parameter int CNT_W    = 12,
  parameter int REQ_LAT  = 1
) (
  input  logic              vga_clk_i,
  input  logic              sys_rst_n_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] pix_data_i,
  output logic              pix_req_o,
  output logic [CNT_W-1:0]  pix_x_o,
  output logic [CNT_W-1:0]  pix_y_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              data_en_o,
  output logic [DATA_W-1:0] rgb_o,
  output logic              frame_start_o,
  output logic [7:0]        frame_cnt_o
);

  // --------------------------------------------------------------------------
  // Derived geometry
  // --------------------------------------------------------------------------
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int HA_S    = H_SYNC + H_BP;
  localparam int HA_E    = HA_S + H_ACTIVE;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int VA_S    = V_SYNC + V_BP;
  localparam int VA_E    = VA_S + V_ACTIVE;

  // Counter-width copies so every compare is same-width.
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_E  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_E  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HA_S_C    = CNT_W'(HA_S);
  localparam logic [CNT_W-1:0] HA_E_C    = CNT_W'(HA_E);
  localparam logic [CNT_W-1:0] VA_S_C    = CNT_W'(VA_S);
  localparam logic [CNT_W-1:0] VA_E_C    = CNT_W'(VA_E);
  localparam logic [CNT_W-1:0] REQ_S_C   = CNT_W'(HA_S - REQ_LAT);
  localparam logic [CNT_W-1:0] REQ_E_C   = CNT_W'(HA_E - REQ_LAT);
  localparam logic [CNT_W-1:0] REQ_LAT_C = CNT_W'(REQ_LAT);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if (REQ_LAT < 1 || REQ_LAT > 4) begin : g_err_req_lat_range
      $error("vga_timing_gen: REQ_LAT must be in 1..4");
    end
    // The request window must start inside the line, i.e. no earlier than
    // the end of the sync pulse region feeding the back porch.
    if (REQ_LAT > H_BP) begin : g_err_req_lat_bp
      $error("vga_timing_gen: REQ_LAT must not exceed H_BP");
    end
    if (H_TOTAL >= (1 << CNT_W)) begin : g_err_h_total
      $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (V_TOTAL >= (1 << CNT_W)) begin : g_err_v_total
      $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic             run_q;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  // Decoded windows (ungated by run)
  logic h_sync_win;
  logic v_sync_win;
  logic h_act_win;
  logic v_act_win;
  logic h_req_win;

  // --------------------------------------------------------------------------
  // Raster counters. While stopped the counters sit at zero, so the first
  // cycle after run rises is always h=0, v=0: a fresh frame with sync first.
  // --------------------------------------------------------------------------
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!run_q) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + CNT_W'(1);
      end
    end else begin
      h_cnt_d = h_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_o) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge vga_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      run_q       <= 1'b0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= 8'd0;
    end else begin
      run_q       <= en_i;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Window decode from the registered counters
  // --------------------------------------------------------------------------
  always_comb begin
    h_sync_win = (h_cnt_q < H_SYNC_E);
    v_sync_win = (v_cnt_q < V_SYNC_E);
    h_act_win  = (h_cnt_q >= HA_S_C)  && (h_cnt_q < HA_E_C);
    v_act_win  = (v_cnt_q >= VA_S_C)  && (v_cnt_q < VA_E_C);
    // Request window is the active window moved REQ_LAT cycles earlier.
    h_req_win  = (h_cnt_q >= REQ_S_C) && (h_cnt_q < REQ_E_C);
  end

  // --------------------------------------------------------------------------
  // Outputs: everything is gated by run_q so stopping (or reset, which
  // clears run_q asynchronously) forces the inactive levels at once.
  // --------------------------------------------------------------------------
  always_comb begin
    hsync_o       = ~HS_POL;
    vsync_o       = ~VS_POL;
    data_en_o     = 1'b0;
    pix_req_o     = 1'b0;
    pix_x_o       = '0;
    pix_y_o       = '0;
    frame_start_o = 1'b0;
    rgb_o         = '0;
    if (run_q) begin
      hsync_o       = h_sync_win ? HS_POL : ~HS_POL;
      vsync_o       = v_sync_win ? VS_POL : ~VS_POL;
      data_en_o     = h_act_win && v_act_win;
      pix_req_o     = h_req_win && v_act_win;
      frame_start_o = (h_cnt_q == '0) && (v_cnt_q == '0);
      if (pix_req_o) begin
        pix_x_o = h_cnt_q + REQ_LAT_C - HA_S_C;
        pix_y_o = v_cnt_q - VA_S_C;
      end
      if (data_en_o) begin
        rgb_o = pix_data_i;
      end
    end
  end

  assign frame_cnt_o = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Directed self-checking bench. Two small-geometry instances
//             share clock, reset and enable:
//               A: H 4/3/8/2 (17), V 2/2/3/1 (8), active-low syncs, REQ_LAT=1
//               B: H 5/4/6/3 (18), V 1/2/3/1 (7), active-high syncs, REQ_LAT=3
//             Each source returns {tag, y, x} of the requested pixel after
//             its REQ_LAT registered stages.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  always #5 clk = ~clk;

  // Instance A signals
  logic [15:0]   pd_a, rgb_a;
  logic          req_a, hs_a, vs_a, de_a, fs_a;
  logic [CW-1:0] px_a, py_a;
  logic [7:0]    fc_a;
  // Instance B signals
  logic [15:0]   pd_b, rgb_b;
  logic          req_b, hs_b, vs_b, de_b, fs_b;
  logic [CW-1:0] px_b, py_b;
  logic [7:0]    fc_b;

  vga_timing_gen #(
    .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(2), .V_BP(2), .V_ACTIVE(3), .V_FP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .DATA_W(16), .CNT_W(CW), .REQ_LAT(1)
  ) u_dut_a (
    .vga_clk_i(clk), .sys_rst_n_i(rst_n), .en_i(en), .pix_data_i(pd_a),
    .pix_req_o(req_a), .pix_x_o(px_a), .pix_y_o(py_a),
    .hsync_o(hs_a), .vsync_o(vs_a), .data_en_o(de_a), .rgb_o(rgb_a),
    .frame_start_o(fs_a), .frame_cnt_o(fc_a)
  );

  vga_timing_gen #(
    .H_SYNC(5), .H_BP(4), .H_ACTIVE(6), .H_FP(3),
    .V_SYNC(1), .V_BP(2), .V_ACTIVE(3), .V_FP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .DATA_W(16), .CNT_W(CW), .REQ_LAT(3)
  ) u_dut_b (
    .vga_clk_i(clk), .sys_rst_n_i(rst_n), .en_i(en), .pix_data_i(pd_b),
    .pix_req_o(req_b), .pix_x_o(px_b), .pix_y_o(py_b),
    .hsync_o(hs_b), .vsync_o(vs_b), .data_en_o(de_b), .rgb_o(rgb_b),
    .frame_start_o(fs_b), .frame_cnt_o(fc_b)
  );

  // Pixel sources: 1 registered stage for A, 3 for B.
  logic [15:0] src_b1, src_b2;
  always @(posedge clk) begin
    pd_a   <= {4'hA, py_a, px_a};
    src_b1 <= {4'h5, py_b, px_b};
    src_b2 <= src_b1;
    pd_b   <= src_b2;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Per-cycle checking state for the two-frame run
  int ha, va, hb, vb;
  logic e_de, e_req;
  logic [15:0] e_rgb;
  logic [CW-1:0] e_px, e_py;
  int err_sync_a, err_de_a, err_req_a, err_rgb_a;
  int err_sync_b, err_de_b, err_req_b, err_rgb_b;
  int de_cnt_a, req_cnt_a, hs_low_a, vs_low_a;
  int de_cnt_b, req_cnt_b, hs_high_b, vs_high_b;
  int fs_cnt_a, fs_last_a, fs_cnt_b, fs_last_b;
  int first_req_a, last_req_a, first_de_b, first_req_b;
  logic [CW-1:0] last_px_a, last_py_a;
  int low_run, high_run;

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    {err_sync_a, err_de_a, err_req_a, err_rgb_a} = '0;
    {err_sync_b, err_de_b, err_req_b, err_rgb_b} = '0;
    {de_cnt_a, req_cnt_a, hs_low_a, vs_low_a}    = '0;
    {de_cnt_b, req_cnt_b, hs_high_b, vs_high_b}  = '0;
    {fs_cnt_a, fs_last_a, fs_cnt_b, fs_last_b}   = '0;
    first_req_a = -1; last_req_a = -1; first_de_b = -1; first_req_b = -1;
    last_px_a = '0; last_py_a = '0;

    // ---- In reset: inactive levels, even with en high ----
    repeat (3) @(negedge clk);
    check("rst_hs_a", hs_a, 1);
    check("rst_vs_a", vs_a, 1);
    check("rst_rgb_a", rgb_a, 0);
    check("rst_de_a", de_a, 0);
    check("rst_req_a", req_a, 0);
    check("rst_fc_a", fc_a, 0);
    check("rst_hs_b", hs_b, 0);
    check("rst_vs_b", vs_b, 0);
    check("rst_fs_b", fs_b, 0);

    // ---- Release; cycle t=0 is the first run cycle ----
    rst_n = 1'b1;
    for (int t = 0; t < 272; t++) begin
      @(negedge clk);
      ha = t % 17; va = (t / 17) % 8;
      hb = t % 18; vb = (t / 18) % 7;

      // Instance A expectations
      if (hs_a !== ((ha < 4) ? 1'b0 : 1'b1)) err_sync_a++;
      if (vs_a !== ((va < 2) ? 1'b0 : 1'b1)) err_sync_a++;
      e_de  = (ha >= 7) && (ha < 15) && (va >= 4) && (va < 7);
      e_req = (ha >= 6) && (ha < 14) && (va >= 4) && (va < 7);
      e_px  = e_req ? CW'(ha - 6) : '0;
      e_py  = e_req ? CW'(va - 4) : '0;
      e_rgb = e_de ? {4'hA, CW'(va - 4), CW'(ha - 7)} : 16'h0;
      if (de_a !== e_de) err_de_a++;
      if (req_a !== e_req || px_a !== e_px || py_a !== e_py) err_req_a++;
      if (rgb_a !== e_rgb) err_rgb_a++;
      if (t < 136) begin
        if (de_a === 1'b1) de_cnt_a++;
        if (req_a === 1'b1) req_cnt_a++;
        if (hs_a === 1'b0) hs_low_a++;
        if (vs_a === 1'b0) vs_low_a++;
        if (req_a === 1'b1 && first_req_a < 0) first_req_a = t;
        if (req_a === 1'b1) begin
          last_req_a = t; last_px_a = px_a; last_py_a = py_a;
        end
      end
      if (fs_a === 1'b1) begin fs_cnt_a++; fs_last_a = t; end

      // Instance B expectations
      if (hs_b !== ((hb < 5) ? 1'b1 : 1'b0)) err_sync_b++;
      if (vs_b !== ((vb < 1) ? 1'b1 : 1'b0)) err_sync_b++;
      e_de  = (hb >= 9) && (hb < 15) && (vb >= 3) && (vb < 6);
      e_req = (hb >= 6) && (hb < 12) && (vb >= 3) && (vb < 6);
      e_px  = e_req ? CW'(hb - 6) : '0;
      e_py  = e_req ? CW'(vb - 3) : '0;
      e_rgb = e_de ? {4'h5, CW'(vb - 3), CW'(hb - 9)} : 16'h0;
      if (de_b !== e_de) err_de_b++;
      if (req_b !== e_req || px_b !== e_px || py_b !== e_py) err_req_b++;
      if (rgb_b !== e_rgb) err_rgb_b++;
      if (t < 126) begin
        if (de_b === 1'b1) de_cnt_b++;
        if (req_b === 1'b1) req_cnt_b++;
        if (hs_b === 1'b1) hs_high_b++;
        if (vs_b === 1'b1) vs_high_b++;
        if (req_b === 1'b1 && first_req_b < 0) first_req_b = t;
        if (de_b === 1'b1 && first_de_b < 0) first_de_b = t;
      end
      if (fs_b === 1'b1) begin fs_cnt_b++; fs_last_b = t; end

      if (t == 0)   check("fc_a_t0", fc_a, 0);
      if (t == 135) check("fc_a_f1", fc_a, 1);
      if (t == 137) check("fc_a_f2", fc_a, 2);
    end

    check("err_sync_a", err_sync_a, 0);
    check("err_de_a", err_de_a, 0);
    check("err_req_a", err_req_a, 0);
    check("err_rgb_a", err_rgb_a, 0);
    check("err_sync_b", err_sync_b, 0);
    check("err_de_b", err_de_b, 0);
    check("err_req_b", err_req_b, 0);
    check("err_rgb_b", err_rgb_b, 0);
    check("de_cnt_a", de_cnt_a, 24);
    check("req_cnt_a", req_cnt_a, 24);
    check("hs_low_a", hs_low_a, 32);
    check("vs_low_a", vs_low_a, 34);
    check("first_req_a", first_req_a, 74);
    check("last_req_a", last_req_a, 115);
    check("last_px_a", last_px_a, 7);
    check("last_py_a", last_py_a, 2);
    check("de_cnt_b", de_cnt_b, 18);
    check("req_cnt_b", req_cnt_b, 18);
    check("hs_high_b", hs_high_b, 35);
    check("vs_high_b", vs_high_b, 18);
    check("first_req_b", first_req_b, 60);
    check("first_de_b", first_de_b, 63);
    check("fs_cnt_a", fs_cnt_a, 2);
    check("fs_last_a", fs_last_a, 136);
    check("fs_cnt_b", fs_cnt_b, 3);
    check("fs_last_b", fs_last_b, 252);

    // ---- Drop en mid-line while A is in its visible region (t=350) ----
    repeat (79) @(negedge clk);
    check("pre_drop_de_a", de_a, 1);
    check("pre_drop_fc_a", fc_a, 3);
    en = 1'b0;
    @(negedge clk);
    check("drop_hs_a", hs_a, 1);
    check("drop_vs_a", vs_a, 1);
    check("drop_de_a", de_a, 0);
    check("drop_req_a", req_a, 0);
    check("drop_rgb_a", rgb_a, 0);
    check("drop_px_a", px_a, 0);
    check("drop_fs_a", fs_a, 0);
    check("drop_hs_b", hs_b, 0);
    check("drop_vs_b", vs_b, 0);
    check("drop_fc_a", fc_a, 3);
    check("drop_fc_b", fc_b, 3);
    repeat (9) @(negedge clk);
    check("hold_fc_a", fc_a, 3);
    check("hold_de_a", de_a, 0);

    // ---- Restart: fresh frame from h=0, v=0 ----
    en = 1'b1;
    @(negedge clk);
    check("rs_fs_a", fs_a, 1);
    check("rs_hs_a", hs_a, 0);
    check("rs_vs_a", vs_a, 0);
    check("rs_fc_a", fc_a, 3);
    check("rs_fs_b", fs_b, 1);
    check("rs_hs_b", hs_b, 1);
    low_run  = 1;
    high_run = 1;
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      if (hs_a === 1'b0) low_run++;
      if (hs_b === 1'b1) high_run++;
    end
    check("rs_hs_low_a", low_run, 4);
    check("rs_hs_high_b", high_run, 5);
    check("rs_fc_a_inc", fc_a, 4);

    // ---- Asynchronous reset mid-line, A visible (restart t=78) ----
    repeat (72) @(negedge clk);
    check("pre_rst_de_a", de_a, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hs_a", hs_a, 1);
    check("arst_vs_a", vs_a, 1);
    check("arst_de_a", de_a, 0);
    check("arst_rgb_a", rgb_a, 0);
    check("arst_req_a", req_a, 0);
    check("arst_fc_a", fc_a, 0);
    check("arst_fc_b", fc_b, 0);
    check("arst_hs_b", hs_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_fs_a", fs_a, 1);
    check("rel_hs_a", hs_a, 0);
    check("rel_vs_a", vs_a, 0);
    check("rel_fc_a", fc_a, 0);
    @(negedge clk);
    check("rel_fc_a_inc", fc_a, 1);
    check("rel_fs_a_off", fs_a, 0);
    repeat (3) @(negedge clk);
    check("rel_hs_a_h4", hs_a, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
